bin_to_bcd_converter: RTL and testbench
=======================================

// Module: bin_to_bcd_converter
// PURPOSE
// - Sequential double-dabble converter: turns an unsigned binary count into packed BCD
//   digits for the 8-digit seven-segment display driver's 32-bit BCD value input.
// - Sits between game/score logic (binary producer) and the display path.
// - One shift/adjust step per clock; start/busy/done handshake; result register holds.
// PARAMETERS
// - BIN_WIDTH  27  width of binary input (27 bits covers 0..99,999,999 plus overflow range)
// - DIGITS     8   number of BCD digits produced; bcd_out width = 4*DIGITS
// PORTS
// - clk_in        input   1            system clock; all state on rising edge
// - rst_n_in      input   1            reset, asynchronous assert, active-low
// - start_in      input   1            request conversion of bin_in; accepted only in IDLE
// - bin_in        input   BIN_WIDTH    unsigned binary value, sampled on accepted start
// - bcd_out       output  4*DIGITS     packed BCD, digit 0 in [3:0]; held until next done
// - busy_out      output  1            high while a conversion is in progress
// - done_out      output  1            single-cycle pulse: bcd_out/overflow_out just updated
// - overflow_out  output  1            last result saturated (bin_in > 10**DIGITS-1)
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low (clk_in, rst_n_in).
// - Reset (rst_n_in=0, any time incl. mid-conversion): state=IDLE, bcd_out=0, busy_out=0,
//   done_out=0, overflow_out=0, shift regs and counter cleared; no done pulse follows.
// - FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start_in=1 at edge k captures bin_in into shift reg, clears BCD scratch,
//         counter=0, ovf flag = (bin_in > 10**DIGITS-1); busy_out=1 from edge k.
//   SHIFT: each edge: every scratch digit >=5 gets +3, then {scratch,shift} shifts left 1;
//         counter increments; after BIN_WIDTH shifts (edge k+BIN_WIDTH) -> DONE.
//   DONE: at edge k+BIN_WIDTH+1: bcd_out <= scratch (or all-9s if ovf flag),
//         overflow_out <= ovf flag, done_out=1 for that one cycle, busy_out=0, -> IDLE.
// - Latency: start accepted at edge k -> done_out high in cycle after edge k+BIN_WIDTH+1.
// - Scratch width 4*DIGITS+4 (guard digit) so no adjust carry is lost; guard digit discarded.
// - Saturation: overflow -> bcd_out = all digits 4'h9, overflow_out=1; else overflow_out=0.
// - start_in while busy (SHIFT or DONE) ignored; no queuing. start_in held high: new
//   conversion accepted in the IDLE cycle right after DONE (back-to-back period BIN_WIDTH+2).
// - bin_in changes after acceptance have no effect on the running conversion.
// - bcd_out never shows partial results; changes only in the done_out cycle.
// - Counter width clog2(BIN_WIDTH+1); no wrap within a conversion.
// CONFIGURATION
// - Macro BCD_BLANK_LEADING_ZEROS_EN.
// - Defined: in DONE, leading zero digits (most-significant downwards, stopping at first
//   nonzero) replaced by 4'hF, the display decoder's blank code; digit 0 never blanked.
//   Saturated (overflow) results are not blanked.
// - Undefined: bcd_out is plain BCD, leading zeros shown as 4'h0; no blanking logic built.
// TESTING (BIN_WIDTH=27, DIGITS=8)
// - Reset: hold rst_n_in=0 -> bcd_out=32'h0, busy_out=0, done_out=0, overflow_out=0.
// - bin_in=12345678, start 1 cycle -> busy 28 cycles, done_out pulse 1 cycle after edge
//   k+28, bcd_out=32'h12345678, overflow_out=0.
// - bin_in=0 -> bcd_out=32'h00000000; with BCD_BLANK_LEADING_ZEROS_EN -> 32'hFFFFFFF0;
//   bin_in=4096 with macro -> 32'hFFFF4096.
// - bin_in=99999999 -> 32'h99999999, overflow_out=0; bin_in=100000000 -> 32'h99999999,
//   overflow_out=1; bin_in=2**27-1 -> 32'h99999999, overflow_out=1.
// - Pulse start_in with bin_in=55 mid-conversion of 777 -> result 32'h00000777 only,
//   exactly one done pulse; start_in held high -> done pulses every 29 cycles.
// - Drop rst_n_in for 1 cycle mid-SHIFT -> outputs cleared immediately, no done_out,
//   next start converts normally.

Source files
------------

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-packed-BCD converter with start/busy/done handshake.
// Optional macro BCD_BLANK_LEADING_ZEROS_EN replaces leading zero digits with the blank code 4'hF.
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 27,
  parameter int DIGITS    = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  overflow_out
);

  localparam int SCR_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

`ifdef BCD_BLANK_LEADING_ZEROS_EN
  // Blank zeros from the most significant digit down until the first nonzero digit.
  function automatic logic [4*DIGITS-1:0] blank_zeros(input logic [4*DIGITS-1:0] v);
    logic lead;
    lead        = 1'b1;
    blank_zeros = v;
    for (int i = DIGITS-1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) begin
        blank_zeros[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  endfunction
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [BIN_WIDTH-1:0]   shift_r;
  logic [SCR_W-1:0]       scratch_r;
  logic [SCR_W-1:0]       adj_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   ovf_r;
  logic [4*DIGITS-1:0]    result_s;
  logic [4*DIGITS-1:0]    bcd_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   overflow_r;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_W'(BIN_WIDTH - 1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Add-3 adjust on every scratch digit (guard digit included) before each shift.
  always_comb begin
    adj_s = scratch_r;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scratch_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = scratch_r[4*i +: 4];
      end
    end
  end

  // Final value presented in the done cycle; saturated results are never blanked.
  always_comb begin
    result_s = scratch_r[4*DIGITS-1:0];
    if (ovf_r) begin
      result_s = {DIGITS{4'h9}};
    end else begin
`ifdef BCD_BLANK_LEADING_ZEROS_EN
      result_s = blank_zeros(scratch_r[4*DIGITS-1:0]);
`else
      result_s = scratch_r[4*DIGITS-1:0];
`endif
    end
  end

  // Datapath, counter and registered handshake outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_r    <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      ovf_r      <= 1'b0;
      bcd_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_in) begin
            shift_r   <= bin_in;
            scratch_r <= '0;
            cnt_r     <= '0;
            ovf_r     <= (64'(bin_in) > MAX_VAL);
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          {scratch_r, shift_r} <= {adj_s, shift_r} << 1;
          cnt_r                <= cnt_r + CNT_W'(1);
          done_r               <= 1'b0;
        end
        ST_DONE: begin
          bcd_r      <= result_s;
          overflow_r <= ovf_r;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_out      = bcd_r;
  assign busy_out     = busy_r;
  assign done_out     = done_r;
  assign overflow_out = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: arithmetic reference model plus directed vectors.
module tb_bin_to_bcd_converter;

  localparam int BW    = 27;
  localparam int DG    = 8;
  localparam int BUSYC = BW + 1;

`ifdef BCD_BLANK_LEADING_ZEROS_EN
  localparam logic [31:0] E0    = 32'hFFFFFFF0;
  localparam logic [31:0] E4096 = 32'hFFFF4096;
  localparam logic [31:0] E777  = 32'hFFFFF777;
  localparam logic [31:0] E321  = 32'hFFFFF321;
  localparam logic [31:0] E42   = 32'hFFFFFF42;
`else
  localparam logic [31:0] E0    = 32'h00000000;
  localparam logic [31:0] E4096 = 32'h00004096;
  localparam logic [31:0] E777  = 32'h00000777;
  localparam logic [31:0] E321  = 32'h00000321;
  localparam logic [31:0] E42   = 32'h00000042;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] bin   = '0;
  logic [31:0]   bcd_out;
  logic          busy_out;
  logic          done_out;
  logic          overflow_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bin_to_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .start_in    (start),
    .bin_in      (bin),
    .bcd_out     (bcd_out),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, saturation, optional blanking.
  function automatic logic [31:0] exp_bcd(input longint v);
    logic [31:0] r;
    longint      t;
    if (v > 64'd99999999) return {DG{4'h9}};
    r = '0;
    t = v;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    begin
      int nd;
      nd = 1;
      t  = v;
      while (t >= 10) begin
        t  = t / 10;
        nd = nd + 1;
      end
      for (int i = 1; i < DG; i++) if (i >= nd) r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Transaction-level model: accept in idle, report result BUSYC edges later.
  int          m_cnt  = 0;
  longint      m_val  = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_bcd  = '0;
  logic        m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_bcd <= '0; m_ovf <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_bcd  <= exp_bcd(m_val);
        m_ovf  <= (m_val > 64'd99999999);
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_val  <= longint'(bin);
        m_busy <= 1'b1;
        m_cnt  <= BUSYC;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy_out), 64'(m_busy));
      check("done", 64'(done_out), 64'(m_done));
      check("bcd", 64'(bcd_out), 64'(m_bcd));
      check("ovf", 64'(overflow_out), 64'(m_ovf));
    end
  end

  task automatic convert(input logic [BW-1:0] v, input logic [31:0] e, input logic eo, input string nm);
    int cyc;
    int bcyc;
    cyc  = 0;
    bcyc = 0;
    @(posedge clk); #2; bin = v; start = 1'b1;
    @(posedge clk); #2; start = 1'b0; bin = BW'($urandom);
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy_out) bcyc++;
      if (done_out) break;
    end
    check({nm, " latency"}, 64'(cyc), 64'd29);
    check({nm, " busy cycles"}, 64'(bcyc), 64'd28);
    check({nm, " bcd"}, 64'(bcd_out), 64'(e));
    check({nm, " overflow"}, 64'(overflow_out), 64'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int t[3];
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset bcd", 64'(bcd_out), 64'h0);
    check("reset busy", 64'(busy_out), 64'h0);
    check("reset done", 64'(done_out), 64'h0);
    check("reset ovf", 64'(overflow_out), 64'h0);
    #1; rst_n = 1'b1;

    convert(BW'(12345678), 32'h12345678, 1'b0, "v12345678");
    convert(BW'(0), E0, 1'b0, "v0");
    convert(BW'(4096), E4096, 1'b0, "v4096");
    convert(BW'(99999999), 32'h99999999, 1'b0, "v99999999");
    convert(BW'(100000000), 32'h99999999, 1'b1, "v100000000");
    convert({BW{1'b1}}, 32'h99999999, 1'b1, "vmax");

    // start pulse while busy must be ignored
    np = 0;
    @(posedge clk); #2; bin = BW'(777); start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; bin = BW'(55); start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_out) np++;
    end
    check("ignore start pulses", 64'(np), 64'd1);
    check("ignore start bcd", 64'(bcd_out), 64'(E777));

    // start held high: back-to-back conversions
    np = 0;
    @(posedge clk); #2; bin = BW'(321); start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_out) begin
        if (np < 3) t[np] = i;
        np++;
      end
    end
    @(posedge clk); #2; start = 1'b0;
    repeat (35) @(negedge clk);
    check("held pulses", 64'(np >= 3), 64'd1);
    check("held period 1", 64'(t[1] - t[0]), 64'd29);
    check("held period 2", 64'(t[2] - t[1]), 64'd29);
    check("held bcd", 64'(bcd_out), 64'(E321));

    // async reset mid-shift
    np = 0;
    @(posedge clk); #2; bin = BW'(5000); start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("midreset bcd", 64'(bcd_out), 64'h0);
    check("midreset busy", 64'(busy_out), 64'h0);
    check("midreset done", 64'(done_out), 64'h0);
    check("midreset ovf", 64'(overflow_out), 64'h0);
    @(posedge clk); #2; rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_out) np++;
    end
    check("midreset no done", 64'(np), 64'd0);
    convert(BW'(42), E42, 1'b0, "after reset");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
